// File: rtl/adc_frame_capture_pkg.sv
// Shared definitions for the ADC receive path: FSM encoding and the default bus/divider
// constants also used by the ADC clock/enable driver.
package adc_frame_capture_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DIV    = 100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } cap_state_t;

endpackage

// File: rtl/adc_frame_capture_if.sv
// Sample output stream of the frame capture block: data, valid/ready handshake, last marker.
interface adc_frame_capture_if
    import adc_frame_capture_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] Dout;
    logic              Dout_Valid;
    logic              Dout_Ready;
    logic              Dout_Last;

    modport master (
        output Dout,
        output Dout_Valid,
        output Dout_Last,
        input  Dout_Ready
    );

    modport slave (
        input  Dout,
        input  Dout_Valid,
        input  Dout_Last,
        output Dout_Ready
    );
endinterface

// File: rtl/adc_frame_capture_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is visible whenever not empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO is still taken.
    assign do_push = push && (!full || do_pop);

    // Masked head so the bus reads zero while nothing is held.
    assign dout = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - (AW+1)'(1);
            end
        end
    end
endmodule

// File: rtl/adc_frame_capture.sv
// ADC receive front end: generates the ADC sample clock, samples the data bus once per
// period and captures Start-requested frames into a FWFT FIFO streamed out with a last flag.
module adc_frame_capture
    import adc_frame_capture_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DIV    = DEF_DIV,
    parameter int DEPTH  = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk_100MHz,
    input  logic              Rst,
    output logic              clk_ADC,
    output logic              ADC_En,
    input  logic [DATA_W-1:0] ADC_Data,
    input  logic              Start,
    input  logic [LEN_W-1:0]  Frame_Len,
    adc_frame_capture_if.master dout_if,
    output logic              Busy,
    output logic              Done,
    output logic              Overflow
);
    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0]  cnt_reg;
    logic              clk_adc_reg;
    logic              adc_en_reg;
    logic              strobe;
    logic [DATA_W-1:0] samp_q;
    logic              samp_pend_reg;

    cap_state_t        state_reg, state_next;
    logic [LEN_W-1:0]  remaining_reg, remaining_next;
    logic              overflow_reg, overflow_next;
    logic              done_reg, done_next;

    logic              fifo_push;
    logic              fifo_last;
    logic              fifo_pop;
    logic [DATA_W:0]   fifo_dout;
    logic              fifo_empty;
    logic              fifo_full;

    // End of the low phase: the bus is stable and clk_ADC rises on this edge.
    assign strobe = (cnt_reg == CNT_W'(DIV-1));

    always_ff @(posedge clk_100MHz or negedge Rst) begin
        if (!Rst) begin
            cnt_reg     <= '0;
            clk_adc_reg <= 1'b0;
            adc_en_reg  <= 1'b1;
        end else begin
            adc_en_reg <= 1'b0;
            if (strobe) begin
                cnt_reg     <= '0;
                clk_adc_reg <= 1'b1;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(DIV/2 - 1)) begin
                    clk_adc_reg <= 1'b0;
                end
            end
        end
    end

    // Strobes only count once the FSM is in CAPTURE; the write follows one edge later.
    always_ff @(posedge clk_100MHz or negedge Rst) begin
        if (!Rst) begin
            samp_q        <= '0;
            samp_pend_reg <= 1'b0;
        end else begin
            if (strobe) begin
                samp_q <= ADC_Data;
            end
            samp_pend_reg <= strobe && (state_reg == ST_CAPTURE);
        end
    end

    always_ff @(posedge clk_100MHz or negedge Rst) begin
        if (!Rst) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            overflow_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            overflow_reg  <= overflow_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        overflow_next  = overflow_reg;
        done_next      = 1'b0;
        fifo_push      = 1'b0;
        fifo_last      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (Start) begin
                    overflow_next = 1'b0;
                    if (Frame_Len != '0) begin
                        remaining_next = Frame_Len;
                        state_next     = ST_CAPTURE;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            ST_CAPTURE: begin
                if (samp_pend_reg) begin
                    // A dropped sample still consumes a frame slot to keep frame timing.
                    fifo_push      = 1'b1;
                    fifo_last      = (remaining_reg == LEN_W'(1));
                    remaining_next = remaining_reg - LEN_W'(1);
                    if (fifo_full && !fifo_pop) begin
                        overflow_next = 1'b1;
                    end
                    if (fifo_last) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign fifo_pop = dout_if.Dout_Valid && dout_if.Dout_Ready;

    sync_fifo_fwft #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_100MHz),
        .rst_n (Rst),
        .push  (fifo_push),
        .din   ({fifo_last, samp_q}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign dout_if.Dout       = fifo_dout[DATA_W-1:0];
    assign dout_if.Dout_Last  = fifo_dout[DATA_W];
    assign dout_if.Dout_Valid = !fifo_empty;

    assign clk_ADC  = clk_adc_reg;
    assign ADC_En   = adc_en_reg;
    assign Busy     = (state_reg != ST_IDLE);
    assign Done     = done_reg;
    assign Overflow = overflow_reg;
endmodule

// File: tb/tb_adc_frame_capture.sv
// Scoreboard bench for adc_frame_capture with DIV=4, DEPTH=4 and a ramping ADC bus model.
module tb_adc_frame_capture;
    localparam int DW    = 8;
    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int LW    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clk_adc;
    logic          adc_en;
    logic [DW-1:0] adc_data = '0;
    logic          start;
    logic [LW-1:0] frame_len;
    logic          busy;
    logic          done;
    logic          overflow;

    int            total = 0;
    int            bad = 0;
    int            done_cnt = 0;
    logic [DW:0]   sb_q[$];
    logic [DW-1:0] ramp_val = '0;

    adc_frame_capture_if #(.DATA_W(DW)) dif ();

    adc_frame_capture #(
        .DATA_W (DW),
        .DIV    (DIV),
        .DEPTH  (DEPTH),
        .LEN_W  (LW)
    ) dut (
        .clk_100MHz (clk),
        .Rst        (rst_n),
        .clk_ADC    (clk_adc),
        .ADC_En     (adc_en),
        .ADC_Data   (adc_data),
        .Start      (start),
        .Frame_Len  (frame_len),
        .dout_if    (dif),
        .Busy       (busy),
        .Done       (done),
        .Overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ADC model: a new value appears on each falling edge of the ADC clock.
    initial begin
        forever begin
            @(negedge clk_adc);
            adc_data = ramp_val;
            ramp_val = ramp_val + 8'd1;
        end
    end

    // Output monitor: every accepted transfer is checked against the scoreboard head.
    initial begin
        logic [DW:0] exp;
        forever begin
            @(negedge clk);
            #1;
            if (done === 1'b1) done_cnt++;
            if (dif.Dout_Valid === 1'b1 && dif.Dout_Ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid", 32'(dif.Dout_Valid), 32'd0);
                end else begin
                    exp = sb_q.pop_front();
                    $display("pop data=%02h last=%0b exp_data=%02h exp_last=%0b",
                             dif.Dout, dif.Dout_Last, exp[DW-1:0], exp[DW]);
                    chk("dout", 32'(dif.Dout), 32'(exp[DW-1:0]));
                    chk("dout_last", 32'(dif.Dout_Last), 32'(exp[DW]));
                end
            end
        end
    end

    // Start issued right after clk_ADC rises, so the first counted strobe samples `base`.
    task automatic start_frame(input int len, input int n_exp, input logic [DW-1:0] base);
        @(posedge clk_adc);
        @(negedge clk);
        ramp_val  = base;
        start     = 1'b1;
        frame_len = LW'(len);
        for (int i = 0; i < n_exp; i++) begin
            sb_q.push_back({(i == len - 1), base + DW'(i)});
        end
        @(negedge clk);
        start = 1'b0;
        $display("start len=%0d base=%02h expect=%0d", len, base, n_exp);
    endtask

    task automatic wait_done(input string tag, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 400) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
        repeat (8) @(negedge clk);
        #2;
        chk({tag, "_done_once"}, 32'(done_cnt), 32'(d0 + 1));
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_clk_adc"}, 32'(clk_adc), 32'd0);
        chk({tag, "_adc_en"}, 32'(adc_en), 32'd1);
        chk({tag, "_valid"}, 32'(dif.Dout_Valid), 32'd0);
        chk({tag, "_last"}, 32'(dif.Dout_Last), 32'd0);
        chk({tag, "_dout"}, 32'(dif.Dout), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        int exp_pat[9] = '{0, 0, 0, 1, 1, 0, 0, 1, 1};
        int d0;

        rst_n          = 1'b0;
        start          = 1'b0;
        frame_len      = '0;
        dif.Dout_Ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_vals("rst");

        // Divider waveform after release
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("clk_adc_%0d", i), 32'(clk_adc), 32'(exp_pat[i]));
            if (i == 0) chk("adc_en_first", 32'(adc_en), 32'd0);
        end

        // Plain three-sample frame
        @(negedge clk);
        dif.Dout_Ready = 1'b1;
        d0 = done_cnt;
        start_frame(3, 3, 8'h10);
        chk("f1_busy", 32'(busy), 32'd1);
        wait_done("f1", d0);
        chk("f1_overflow", 32'(overflow), 32'd0);

        // Backpressure: six samples into four slots, two dropped including the last
        dif.Dout_Ready = 1'b0;
        d0 = done_cnt;
        start_frame(6, 4, 8'h20);
        repeat (6) @(posedge clk_adc);
        repeat (3) @(negedge clk);
        #1;
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_valid_held", 32'(dif.Dout_Valid), 32'd1);
        dif.Dout_Ready = 1'b1;
        wait_done("ovf", d0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Zero-length request: immediate Done, clears Overflow, stays idle
        @(negedge clk);
        start     = 1'b1;
        frame_len = '0;
        @(negedge clk);
        start = 1'b0;
        #1;
        $display("start len=0");
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        chk("len0_overflow", 32'(overflow), 32'd0);
        chk("len0_valid", 32'(dif.Dout_Valid), 32'd0);
        @(negedge clk);
        #1;
        chk("len0_done_fall", 32'(done), 32'd0);

        // Start during CAPTURE is ignored
        d0 = done_cnt;
        start_frame(2, 2, 8'h40);
        start     = 1'b1;
        frame_len = LW'(9);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("ign_busy", 32'(busy), 32'd1);
        wait_done("ign", d0);
        repeat (40) @(negedge clk);
        #2;
        chk("ign_no_restart", 32'(busy), 32'd0);
        chk("ign_no_done", 32'(done_cnt), 32'(d0 + 1));

        // Reset mid-capture
        dif.Dout_Ready = 1'b0;
        start_frame(8, 0, 8'h60);
        repeat (3) @(posedge clk_adc);
        repeat (2) @(negedge clk);
        #1;
        chk("mid_valid_before", 32'(dif.Dout_Valid), 32'd1);
        chk("mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid");
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        dif.Dout_Ready = 1'b1;
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        #2;
        chk("mid_no_done", 32'(done_cnt), 32'(d0));
        chk("mid_no_valid", 32'(dif.Dout_Valid), 32'd0);
        chk("mid_adc_en", 32'(adc_en), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
